div_iter_unit: RTL

- Multi-cycle radix-2 restoring divider.
- Acts as the responder side of the ALU's divide handshake (start/annul/ready) for DIV and DIVU.
- Produces {remainder, quotient} in HI/LO order for the hilo path.
- Operands are latched at start. The ALU holds start high and stalls the pipeline until ready is seen.

---
 rtl/div_iter_unit.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/div_iter_unit.sv
// Multi-cycle radix-2 restoring divider for the ALU's DIV/DIVU path.
// Produces {remainder, quotient} (HI/LO order) after DATA_W iterations.
// Handshake: start_i is raised and held by the requester until ready_o
// is seen. ready_o/result_o then hold until start_i drops, and both clear
// on the edge that returns the unit to FREE. annul_i aborts an in-flight
// operation (ON or BYZERO) without a ready pulse.
module div_iter_unit #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_BYZERO = 2'd1,
    ST_ON     = 2'd2,
    ST_END    = 2'd3
  } state_t;

  // Current FSM state; kept as a named signal so checkers can bind to it.
  state_t             state;
  logic [CNT_W-1:0]   counter;
  logic [DATA_W-1:0]  rem;
  logic [DATA_W-1:0]  quo;
  logic [DATA_W-1:0]  dvs;
  logic               dividend_neg;
  logic               divisor_neg;
  logic               signed_op;

  logic [DATA_W-1:0]  abs_dividend;
  logic [DATA_W-1:0]  abs_divisor;
  logic [DATA_W:0]    trial;
  logic [DATA_W-1:0]  quo_fixed;
  logic [DATA_W-1:0]  rem_fixed;

  // Operand magnitudes (two's-complement negate only for signed requests),
  // one-bit-wider trial subtract, and the final sign fix-up.
  always_comb begin
    abs_dividend = opdata1_i;
    abs_divisor  = opdata2_i;
    if (signed_div_i && opdata1_i[DATA_W-1]) abs_dividend = -opdata1_i;
    if (signed_div_i && opdata2_i[DATA_W-1]) abs_divisor  = -opdata2_i;

    trial = {rem, quo[DATA_W-1]} - {1'b0, dvs};

    quo_fixed = quo;
    rem_fixed = rem;
    if (signed_op && (dividend_neg ^ divisor_neg)) quo_fixed = -quo;
    if (signed_op && dividend_neg)                 rem_fixed = -rem;
  end

  // Divider FSM: operand latch, one restoring step per edge, result hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_FREE;
      counter      <= '0;
      rem          <= '0;
      quo          <= '0;
      dvs          <= '0;
      dividend_neg <= 1'b0;
      divisor_neg  <= 1'b0;
      signed_op    <= 1'b0;
      result_o     <= '0;
      ready_o      <= 1'b0;
    end else begin
      case (state)
        ST_FREE: begin
          result_o <= '0;
          ready_o  <= 1'b0;
          if (start_i && !annul_i) begin
            if (opdata2_i == '0) begin
              state <= ST_BYZERO;
            end else begin
              state        <= ST_ON;
              counter      <= '0;
              rem          <= '0;
              quo          <= abs_dividend;
              dvs          <= abs_divisor;
              dividend_neg <= opdata1_i[DATA_W-1];
              divisor_neg  <= opdata2_i[DATA_W-1];
              signed_op    <= signed_div_i;
            end
          end
        end
        ST_BYZERO: begin
          if (annul_i) begin
            state    <= ST_FREE;
            result_o <= '0;
            ready_o  <= 1'b0;
          end else begin
            state    <= ST_END;
            result_o <= '0;
            ready_o  <= 1'b1;
          end
        end
        ST_ON: begin
          if (annul_i) begin
            state    <= ST_FREE;
            result_o <= '0;
            ready_o  <= 1'b0;
          end else if (counter == CNT_W'(DATA_W)) begin
            state    <= ST_END;
            result_o <= {rem_fixed, quo_fixed};
            ready_o  <= 1'b1;
          end else begin
            // Restoring step: keep the difference only if it did not borrow.
            if (!trial[DATA_W]) begin
              rem <= trial[DATA_W-1:0];
              quo <= {quo[DATA_W-2:0], 1'b1};
            end else begin
              rem <= {rem[DATA_W-2:0], quo[DATA_W-1]};
              quo <= {quo[DATA_W-2:0], 1'b0};
            end
            counter <= counter + 1'b1;
          end
        end
        ST_END: begin
          if (!start_i) begin
            state    <= ST_FREE;
            result_o <= '0;
            ready_o  <= 1'b0;
          end
        end
        default: begin
          state    <= ST_FREE;
          result_o <= '0;
          ready_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule
